mul_hazard_unit: RTL
====================

# mul_hazard_unit

Issue-side scoreboard for the 4-cycle pipelined multiplier. It sits in decode, directly upstream of the multiplier pipeline. It tracks the destination register of every in-flight multiply and stalls decode on three kinds of hazard: RAW, WAW, and writeback-port collisions. It also raises bypass selects when an operand can be taken from the multiplier result in its writeback cycle. Its shift register advances in lock-step with the multiplier's internal stage registers, so each entry's position always matches the stage its multiply occupies.

## Interface
Parameters:
- MUL_LAT, 4, cycles (clock edges) from multiply issue to result at multiplier output; legal range 2..8
- ALU_LAT, 1, edges from non-multiply issue to its writeback cycle; legal range 1..MUL_LAT-1

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; clears all state immediately
- id_valid  in  1  decode holds a valid instruction
- id_is_mul  in  1  instruction is a multiply (sel == SEL_MUL)
- id_regwrite  in  1  instruction writes rd
- id_rs1  in  5  source register 1 (x0 means unused)
- id_rs2  in  5  source register 2 (x0 means unused)
- id_rd  in  5  destination register
- stall  out  1  hold decode/fetch; instruction not issued this cycle
- issue  out  1  id_valid & ~stall
- byp_rs1  out  1  take rs1 operand from multiplier result this cycle
- byp_rs2  out  1  take rs2 operand from multiplier result this cycle
- wb_mul_valid  out  1  a multiply writes back this cycle
- wb_mul_rd  out  5  destination register of that multiply
- pend_cnt  out  4  number of valid scoreboard entries
- busy  out  1  pend_cnt != 0

## Operation
- The scoreboard is pend[0..MUL_LAT-1], and each entry is {v, rd}. Index i means the multiply writes back after i more edges.
- Every edge: pend[i] <= pend[i+1] for i < MUL_LAT-1. pend[0] retires (falls out).
- Insertion on an edge where issue & id_is_mul & id_regwrite & id_rd != 0:
  - pend[MUL_LAT-1] <= {1, id_rd}.
  - Otherwise pend[MUL_LAT-1] <= {0, 0}.
  - A multiply to x0 is never inserted.
- wb_mul_valid = pend[0].v and wb_mul_rd = pend[0].rd. Both match the multiplier's registered output and regmul_Out in the same cycle.
- Let hit(r, i) = pend[i].v & pend[i].rd == r & r != 0.
- RAW stall: id_valid & (hit(rs1, i) or hit(rs2, i)) for any i >= 1.
- Bypass: byp_rsN = id_valid & hit(rsN, 0) & ~(hit(rsN, i) for any i >= 1).
  - The youngest matching entry wins, so a match at index 0 yields a stall, not a bypass, if a younger entry also matches.
  - Bypass is asserted even when stall is high for another reason.
- WAW stall: id_valid & id_regwrite & hit(id_rd, i) for any i >= ALU_LAT. This applies to multiplies and non-multiplies.
- Writeback collision stall: id_valid & id_regwrite & ~id_is_mul & pend[ALU_LAT].v.
- stall = RAW | WAW | collision. It is purely combinational from the current inputs and state.
- A stalled instruction is not inserted, but the scoreboard still shifts. Stalls therefore always resolve within MUL_LAT-1 cycles.
- pend_cnt is the popcount of pend[*].v and is registered with the state.

## Timing
- Reset (asynchronous, any time, including mid-operation): all entries go to {0, 0}, so pend_cnt = 0 and busy = 0.
  - All combinational outputs then follow from the empty state: stall = 0, byp = 0, wb_mul_valid = 0, wb_mul_rd = 0.
  - In-flight multiplies are forgotten; the multiplier is reset by the same rst.
- The stall, byp and issue paths are combinational from id_* to outputs, with zero latency.
- A multiply issued in cycle t:
  - appears at pend[MUL_LAT-1] after edge t+1;
  - reaches pend[0] in cycle t+MUL_LAT (wb_mul_valid = 1 for exactly one cycle);
  - is gone in cycle t+MUL_LAT+1.
- Back-to-back multiplies, one per cycle, are allowed, with up to MUL_LAT entries valid. pend_cnt reaches MUL_LAT without overflow.
- A simultaneous insert and retire in the same edge leaves pend_cnt unchanged.

## Test plan
- Reset mid-flight: issue mul x5 in cycle 0, assert rst in cycle 2 → pend_cnt = 0, busy = 0, wb_mul_valid never rises.
- RAW: mul x5 issued in cycle 0, then add x6 = x5 + x1 held valid.
  - stall = 1 in cycles 1-3.
  - Cycle 4: stall = 0, byp_rs1 = 1, wb_mul_rd = 5.
- x0 handling: mul x0 issued, then an instruction reading x0 → no stall, pend_cnt stays 0.
- Collision (ALU_LAT = 1): mul x7 issued in cycle 0, then non-mul add x8 (regwrite) in cycle 3 → stall = 1 in cycle 3, issue succeeds in cycle 4.
- WAW: mul x9 issued in cycle 0, then addi x9 in cycle 1 → stall in cycles 1-3, issue in cycle 4.
- Throughput: muls to x1-x4 issued in cycles 0-3 → pend_cnt = 4 in cycle 4; wb_mul_rd = 1, 2, 3, 4 in cycles 4-7; busy = 0 in cycle 8.

Source files
------------

// File: rtl/mul_hazard_unit.sv
// Decode-side scoreboard for the pipelined multiplier: tracks in-flight multiply
// destinations, raises RAW/WAW/writeback-collision stalls and result bypass selects.
module mul_hazard_unit #(
    parameter int MUL_LAT = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_is_mul,
    input  logic       id_regwrite,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    output logic       stall,
    output logic       issue,
    output logic       byp_rs1,
    output logic       byp_rs2,
    output logic       wb_mul_valid,
    output logic [4:0] wb_mul_rd,
    output logic [3:0] pend_cnt,
    output logic       busy
);

    // Entry i writes back after i more edges; index 0 is the writeback cycle.
    localparam logic [MUL_LAT-1:0] OLDER_MASK = {{(MUL_LAT-1){1'b1}}, 1'b0};
    localparam logic [MUL_LAT-1:0] WAW_MASK   = {MUL_LAT{1'b1}} << ALU_LAT;

    logic [MUL_LAT-1:0] pend_v_q;
    logic [MUL_LAT-1:0] pend_v_d;
    logic [4:0]         pend_rd_q [MUL_LAT];
    logic [4:0]         pend_rd_d [MUL_LAT];
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;

    logic [MUL_LAT-1:0] hit_rs1;
    logic [MUL_LAT-1:0] hit_rs2;
    logic [MUL_LAT-1:0] hit_rd;
    logic               raw_rs1;
    logic               raw_rs2;
    logic               raw_stall;
    logic               waw_stall;
    logic               coll_stall;
    logic               insert;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_hit
            assign hit_rs1[gi] = pend_v_q[gi] && (pend_rd_q[gi] == id_rs1) && (id_rs1 != 5'd0);
            assign hit_rs2[gi] = pend_v_q[gi] && (pend_rd_q[gi] == id_rs2) && (id_rs2 != 5'd0);
            assign hit_rd[gi]  = pend_v_q[gi] && (pend_rd_q[gi] == id_rd)  && (id_rd  != 5'd0);
        end
    endgenerate

    // A younger match (index >= 1) overrides the writeback-cycle match.
    assign raw_rs1    = |(hit_rs1 & OLDER_MASK);
    assign raw_rs2    = |(hit_rs2 & OLDER_MASK);
    assign raw_stall  = id_valid && (raw_rs1 || raw_rs2);
    assign waw_stall  = id_valid && id_regwrite && (|(hit_rd & WAW_MASK));
    assign coll_stall = id_valid && id_regwrite && !id_is_mul && pend_v_q[ALU_LAT];

    assign stall   = raw_stall || waw_stall || coll_stall;
    assign issue   = id_valid && !stall;
    assign byp_rs1 = id_valid && hit_rs1[0] && !raw_rs1;
    assign byp_rs2 = id_valid && hit_rs2[0] && !raw_rs2;

    // Writes to x0 are architecturally discarded, so they never occupy an entry.
    assign insert = issue && id_is_mul && id_regwrite && (id_rd != 5'd0);

    generate
        for (gi = 0; gi < MUL_LAT - 1; gi++) begin : g_shift
            assign pend_v_d[gi]  = pend_v_q[gi+1];
            assign pend_rd_d[gi] = pend_rd_q[gi+1];
        end
    endgenerate

    assign pend_v_d[MUL_LAT-1]  = insert;
    assign pend_rd_d[MUL_LAT-1] = insert ? id_rd : 5'd0;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            cnt_d = cnt_d + 4'(pend_v_d[i]);
        end
    end

    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_v_q[gi]  <= 1'b0;
                    pend_rd_q[gi] <= 5'd0;
                end else begin
                    pend_v_q[gi]  <= pend_v_d[gi];
                    pend_rd_q[gi] <= pend_rd_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_mul_valid = pend_v_q[0];
    assign wb_mul_rd    = pend_rd_q[0];
    assign pend_cnt     = cnt_q;
    assign busy         = (cnt_q != 4'd0);

endmodule
